// File: rtl/pll_freq_sched.sv
// -----------------------------------------------------------------------------
// pll_freq_sched
//
// Frequency-step scheduler for the SDRAM memory-test PLL. Decodes step-up,
// step-down and auto-sweep requests into a slot index (pos), then walks the
// pll_reconfig core through ROM load, reconfigure (with timeout) and PLL
// re-lock.
//
// Optional build macro: PLL_SCHED_RETRY_EN
//   defined   : the first RUN timeout resets the reconfig core and retries
//               once from LOAD; timeout_err is set only if the retry also
//               times out.
//   undefined : a RUN timeout resets the core, sets timeout_err and goes on
//               to wait for lock.
//
// Ports
//   clock_50_i      in   system clock
//   RESET           in   synchronous, active-high reset
//   req_up          in   pulse: step to a faster slot (pos-1)
//   req_down        in   pulse: step to a slower slot (pos+1)
//   req_auto        in   pulse: toggle auto-sweep
//   auto_step       in   level: tester saw pass and fail; advance in auto mode
//   pll_busy        in   busy from pll_reconfig
//   pll_locked      in   PLL locked (already synchronised)
//   pos[3:0]        out  current slot index (0 = fastest)
//   auto            out  auto-sweep active
//   write_from_rom  out  one-cycle pulse to pll_reconfig
//   reconfig        out  one-cycle pulse to pll_reconfig
//   reconfig_reset  out  one-cycle pulse resetting a stuck pll_reconfig
//   recfg           out  high while a reconfiguration is in progress
//   done            out  one-cycle pulse when a reconfiguration completes
//   timeout_err     out  sticky; set on timeout, cleared by next accepted request
//   state_dbg[2:0]  out  current FSM state (debug visibility)
//
// Handshake: requests are single-cycle pulses sampled on the rising edge; the
// pll_reconfig strobes are single-cycle pulses, and completion is reported by
// a single-cycle done pulse on the same edge that recfg falls. All outputs are
// registered.
// -----------------------------------------------------------------------------
module pll_freq_sched #(
  parameter int NUM_POS   = 11,
  parameter int INIT_POS  = 7,
  parameter int TIMEOUT   = 1000,
  parameter int LOCK_WAIT = 256
) (
  input  logic       clock_50_i,
  input  logic       RESET,
  input  logic       req_up,
  input  logic       req_down,
  input  logic       req_auto,
  input  logic       auto_step,
  input  logic       pll_busy,
  input  logic       pll_locked,
  output logic [3:0] pos,
  output logic       auto,
  output logic       write_from_rom,
  output logic       reconfig,
  output logic       reconfig_reset,
  output logic       recfg,
  output logic       done,
  output logic       timeout_err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_SCAN      = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_KICK      = 3'd4,
    S_RUN       = 3'd5,
    S_LOCK      = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    R_NONE = 2'd0,
    R_UP   = 2'd1,
    R_DOWN = 2'd2,
    R_AUTO = 2'd3
  } req_t;

  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam int LWW = $clog2(LOCK_WAIT + 1);

  localparam logic [3:0]     LAST_POS = 4'(NUM_POS - 1);
  localparam logic [3:0]     INIT_VAL = 4'(INIT_POS);
  localparam logic [CW-1:0]  TO_VAL   = CW'(TIMEOUT);
  localparam logic [CW-1:0]  TO_LAST  = CW'(2);
  localparam logic [LWW-1:0] LW_LAST  = LWW'(LOCK_WAIT - 1);

  state_t         state;
  req_t           pend_kind;
  logic           pend_valid;
  logic [CW-1:0]  run_cnt;
  logic [LWW-1:0] lock_cnt;
`ifdef PLL_SCHED_RETRY_EN
  logic           retried;
`endif

  // Request decode (only consumed in IDLE)
  req_t       btn_req;
  req_t       eff_req;
  logic       accept;
  logic [3:0] pos_nxt;
  logic       auto_nxt;

  always_comb begin
    btn_req = R_NONE;
    if (req_auto)      btn_req = R_AUTO;
    else if (req_down) btn_req = R_DOWN;
    else if (req_up)   btn_req = R_UP;

    // A fresh button press is newer than anything pended during the last run.
    eff_req = btn_req;
    if (btn_req == R_NONE && pend_valid) eff_req = pend_kind;

    accept   = 1'b0;
    pos_nxt  = pos;
    auto_nxt = auto;
    case (eff_req)
      R_AUTO: begin
        accept = 1'b1;
        if (auto) begin
          auto_nxt = 1'b0;
        end else begin
          auto_nxt = 1'b1;
          pos_nxt  = 4'd0;
        end
      end
      R_DOWN: begin
        if (pos < LAST_POS) begin
          accept   = 1'b1;
          pos_nxt  = pos + 4'd1;
          auto_nxt = 1'b0;
        end
      end
      R_UP: begin
        if (pos != 4'd0) begin
          accept   = 1'b1;
          pos_nxt  = pos - 4'd1;
          auto_nxt = 1'b0;
        end
      end
      default: begin
        // auto_step is a level, never pended; only honoured here in IDLE.
        if (auto_step && auto && (pos < LAST_POS)) begin
          accept  = 1'b1;
          pos_nxt = pos + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clock_50_i) begin
    if (RESET) begin
      state          <= S_IDLE;
      pos            <= INIT_VAL;
      auto           <= 1'b0;
      write_from_rom <= 1'b0;
      reconfig       <= 1'b0;
      reconfig_reset <= 1'b0;
      recfg          <= 1'b0;
      done           <= 1'b0;
      timeout_err    <= 1'b0;
      pend_valid     <= 1'b0;
      pend_kind      <= R_NONE;
      run_cnt        <= '0;
      lock_cnt       <= '0;
`ifdef PLL_SCHED_RETRY_EN
      retried        <= 1'b0;
`endif
    end else begin
      write_from_rom <= 1'b0;
      reconfig       <= 1'b0;
      reconfig_reset <= 1'b0;
      done           <= 1'b0;

      // Button presses during a reconfiguration go to the one-entry slot.
      if (state != S_IDLE && btn_req != R_NONE) begin
        pend_valid <= 1'b1;
        pend_kind  <= btn_req;
      end

      case (state)
        S_IDLE: begin
          // The slot is consumed (or dropped if now out of range) here.
          pend_valid <= 1'b0;
          pend_kind  <= R_NONE;
          if (accept) begin
            pos            <= pos_nxt;
            auto           <= auto_nxt;
            timeout_err    <= 1'b0;
            write_from_rom <= 1'b1;
            recfg          <= 1'b1;
            state          <= S_LOAD;
`ifdef PLL_SCHED_RETRY_EN
            retried        <= 1'b0;
`endif
          end
        end
        S_LOAD: state <= S_SCAN;
        S_SCAN: state <= S_WAIT_BUSY;
        S_WAIT_BUSY: begin
          if (!pll_busy) begin
            reconfig <= 1'b1;
            state    <= S_KICK;
          end
        end
        S_KICK: begin
          run_cnt <= TO_VAL;
          state   <= S_RUN;
        end
        S_RUN: begin
          run_cnt <= run_cnt - CW'(1);
          // run_cnt still equal to TO_VAL means this is the first RUN cycle.
          if (run_cnt != TO_VAL && !pll_busy) begin
            lock_cnt <= '0;
            state    <= S_LOCK;
          end else if (run_cnt == TO_LAST) begin
            reconfig_reset <= 1'b1;
`ifdef PLL_SCHED_RETRY_EN
            if (!retried) begin
              retried        <= 1'b1;
              write_from_rom <= 1'b1;
              state          <= S_LOAD;
            end else begin
              timeout_err <= 1'b1;
              lock_cnt    <= '0;
              state       <= S_LOCK;
            end
`else
            timeout_err <= 1'b1;
            lock_cnt    <= '0;
            state       <= S_LOCK;
`endif
          end
        end
        S_LOCK: begin
          if (!pll_locked) begin
            lock_cnt <= '0;
          end else if (lock_cnt == LW_LAST) begin
            lock_cnt <= '0;
            done     <= 1'b1;
            recfg    <= 1'b0;
            state    <= S_IDLE;
          end else begin
            lock_cnt <= lock_cnt + LWW'(1);
          end
        end
        default: begin
          recfg <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pll_freq_sched.sv
// -----------------------------------------------------------------------------
// tb_pll_freq_sched
//
// Directed bench for pll_freq_sched with a shortened timeout and lock wait.
// Each request issued pushes its expected completion record (final pos/auto/
// timeout_err, strobe counts, reconfig offset, done latency) into exp_q; a
// monitor on the falling edge measures each reconfiguration and pops/compares
// on every done pulse. Latencies are counted from the LOAD cycle (offset 0):
//   busy=0     : KICK at 3, LOCK at 6, done at 6+LOCK_WAIT = 14
//   timeout    : RUN lasts TIMEOUT-1 cycles -> LOCK at 15, done at 23
//   retry build: second LOAD at 15, second LOCK at 30, done at 38
// -----------------------------------------------------------------------------
module tb_pll_freq_sched;

  localparam int TIMEOUT   = 12;
  localparam int LOCK_WAIT = 8;
  localparam int EW        = 42;

  logic       clock_50_i = 1'b0;
  logic       RESET      = 1'b1;
  logic       req_up     = 1'b0;
  logic       req_down   = 1'b0;
  logic       req_auto   = 1'b0;
  logic       auto_step  = 1'b0;
  logic       pll_busy   = 1'b0;
  logic       pll_locked = 1'b1;
  logic [3:0] pos;
  logic       auto;
  logic       write_from_rom;
  logic       reconfig;
  logic       reconfig_reset;
  logic       recfg;
  logic       done;
  logic       timeout_err;
  logic [2:0] state_dbg;

  pll_freq_sched #(
    .NUM_POS   (11),
    .INIT_POS  (7),
    .TIMEOUT   (TIMEOUT),
    .LOCK_WAIT (LOCK_WAIT)
  ) dut (
    .clock_50_i     (clock_50_i),
    .RESET          (RESET),
    .req_up         (req_up),
    .req_down       (req_down),
    .req_auto       (req_auto),
    .auto_step      (auto_step),
    .pll_busy       (pll_busy),
    .pll_locked     (pll_locked),
    .pos            (pos),
    .auto           (auto),
    .write_from_rom (write_from_rom),
    .reconfig       (reconfig),
    .reconfig_reset (reconfig_reset),
    .recfg          (recfg),
    .done           (done),
    .timeout_err    (timeout_err),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #10 clock_50_i = ~clock_50_i;

  int cyc = 0;
  always @(posedge clock_50_i) cyc <= cyc + 1;

  // ---------------- scoreboard bookkeeping ----------------
  logic [EW-1:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic note_fail(input string name);
    chk_cnt++;
    $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
  endtask

  function automatic logic [EW-1:0] mk_exp(input int p, input int a, input int e, input int wfr,
                                           input int rc, input int rr, input int kick, input int lat);
    return {4'(p), 1'(a), 1'(e), 4'(wfr), 4'(rc), 4'(rr), 8'(kick), 16'(lat)};
  endfunction

  // ---------------- monitor ----------------
  logic in_op = 1'b0;
  int t0, wfr_n, rc_n, rr_n, kick_n;

  always @(negedge clock_50_i) begin
    logic [EW-1:0] e;
    if (RESET) begin
      in_op = 1'b0;
    end else begin
      if (write_from_rom && !in_op) begin
        in_op = 1'b1; t0 = cyc; wfr_n = 0; rc_n = 0; rr_n = 0; kick_n = 0;
      end
      if (write_from_rom) wfr_n++;
      if (reconfig) begin
        if (rc_n == 0) kick_n = cyc - t0;
        rc_n++;
      end
      if (reconfig_reset) rr_n++;
      if (done) begin
        if (exp_q.size() == 0) begin
          note_fail("unexpected_done");
        end else begin
          e = exp_q.pop_front();
          check("done_pos",      32'(pos),         32'(e[41:38]));
          check("done_auto",     32'(auto),        32'(e[37]));
          check("done_err",      32'(timeout_err), 32'(e[36]));
          check("wfr_pulses",    32'(wfr_n),       32'(e[35:32]));
          check("reconfig_puls", 32'(rc_n),        32'(e[31:28]));
          check("rreset_pulses", 32'(rr_n),        32'(e[27:24]));
          check("kick_offset",   32'(kick_n),      32'(e[23:16]));
          check("done_latency",  32'(cyc - t0),    32'(e[15:0]));
        end
        in_op = 1'b0;
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic pulse(input int which);
    case (which)
      0: req_up = 1'b1;
      1: req_down = 1'b1;
      default: req_auto = 1'b1;
    endcase
    @(negedge clock_50_i);
    req_up = 1'b0; req_down = 1'b0; req_auto = 1'b0;
  endtask

  task automatic wait_sig(input int which, input int budget, input string name);
    int n = 0;
    while (!(which == 0 ? reconfig : reconfig_reset) && n < budget) begin
      @(negedge clock_50_i); n++;
    end
    if (n >= budget) note_fail(name);
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || recfg) && n < budget) begin
      @(negedge clock_50_i); n++;
    end
    if (n >= budget) note_fail("wait_quiet");
    @(negedge clock_50_i);
  endtask

  task automatic watch_idle(input int n, output logic saw);
    saw = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock_50_i);
      if (recfg || done || write_from_rom) saw = 1'b1;
    end
  endtask

  task automatic summary();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic saw;
    repeat (3) @(negedge clock_50_i);
    RESET = 1'b0;
    check("rst_pos",   32'(pos), 32'd7);
    check("rst_auto",  32'(auto), 32'd0);
    check("rst_recfg", 32'(recfg), 32'd0);
    check("rst_strobes", 32'({write_from_rom, reconfig, reconfig_reset, done}), 32'd0);
    check("rst_err",   32'(timeout_err), 32'd0);
    @(negedge clock_50_i);

    // Basic step up and back down.
    exp_q.push_back(mk_exp(6, 0, 0, 1, 1, 0, 3, 14));
    pulse(0);
    wait_quiet(60);
    exp_q.push_back(mk_exp(7, 0, 0, 1, 1, 0, 3, 14));
    pulse(1);
    wait_quiet(60);

    // Auto-sweep from 7: jump to 0, then one step per reconfiguration to 10.
    exp_q.push_back(mk_exp(0, 1, 0, 1, 1, 0, 3, 14));
    for (int p = 1; p <= 10; p++) exp_q.push_back(mk_exp(p, 1, 0, 1, 1, 0, 3, 14));
    pulse(2);
    auto_step = 1'b1;
    wait_quiet(400);
    watch_idle(10, saw);
    check("sweep_stops", 32'(saw), 32'd0);
    check("sweep_pos",   32'(pos), 32'd10);
    check("sweep_auto",  32'(auto), 32'd1);
    auto_step = 1'b0;

    // req_down at the slowest slot is ignored.
    pulse(1);
    watch_idle(10, saw);
    check("down_limit_idle", 32'(saw), 32'd0);
    check("down_limit_pos",  32'(pos), 32'd10);

    // req_auto while auto: leave auto, pos unchanged.
    exp_q.push_back(mk_exp(10, 0, 0, 1, 1, 0, 3, 14));
    pulse(2);
    wait_quiet(60);
    exp_q.push_back(mk_exp(0, 1, 0, 1, 1, 0, 3, 14));
    pulse(2);
    wait_quiet(60);

    // req_up at the fastest slot is ignored.
    pulse(0);
    watch_idle(10, saw);
    check("up_limit_idle", 32'(saw), 32'd0);
    check("up_limit_pos",  32'(pos), 32'd0);
    exp_q.push_back(mk_exp(0, 0, 0, 1, 1, 0, 3, 14));
    pulse(2);
    wait_quiet(60);
    exp_q.push_back(mk_exp(1, 0, 0, 1, 1, 0, 3, 14));
    pulse(1);
    wait_quiet(60);

    // Pending: req_up then req_down during the run; only the down survives.
    exp_q.push_back(mk_exp(0, 0, 0, 1, 1, 0, 3, 14));
    exp_q.push_back(mk_exp(1, 0, 0, 1, 1, 0, 3, 14));
    pulse(0);
    wait_sig(0, 20, "wait_kick_pend");
    req_up = 1'b1;
    @(negedge clock_50_i);
    req_up = 1'b0; req_down = 1'b1;
    @(negedge clock_50_i);
    req_down = 1'b0;
    wait_quiet(120);

    // Timeout: busy stuck high through RUN.
`ifdef PLL_SCHED_RETRY_EN
    exp_q.push_back(mk_exp(2, 0, 1, 2, 2, 2, 3, 38));
`else
    exp_q.push_back(mk_exp(2, 0, 1, 1, 1, 1, 3, 23));
`endif
    pulse(1);
    wait_sig(0, 20, "wait_kick_to");
    pll_busy = 1'b1;
    wait_sig(1, 2 * TIMEOUT + 10, "wait_rreset");
    pll_busy = 1'b0;
`ifdef PLL_SCHED_RETRY_EN
    wait_sig(0, 20, "wait_kick_retry");
    pll_busy = 1'b1;
    wait_sig(1, 2 * TIMEOUT + 10, "wait_rreset_retry");
    pll_busy = 1'b0;
`endif
    wait_quiet(120);

    // Next accepted request clears the error; a lock drop restarts the count.
    exp_q.push_back(mk_exp(3, 0, 0, 1, 1, 0, 3, 16));
    pulse(1);
    check("err_cleared", 32'(timeout_err), 32'd0);
    wait_sig(0, 20, "wait_kick_glitch");
    repeat (4) @(negedge clock_50_i);
    pll_locked = 1'b0;
    @(negedge clock_50_i);
    pll_locked = 1'b1;
    wait_quiet(80);

    // RESET in LOCK with a pending request: everything back to reset values.
    pulse(0);
    wait_sig(0, 20, "wait_kick_rst");
    pulse(1);
    repeat (4) @(negedge clock_50_i);
    check("pre_rst_state", 32'(state_dbg), 32'd6);
    RESET = 1'b1;
    @(negedge clock_50_i);
    RESET = 1'b0;
    check("mid_rst_pos",   32'(pos), 32'd7);
    check("mid_rst_recfg", 32'(recfg), 32'd0);
    check("mid_rst_done",  32'(done), 32'd0);
    check("mid_rst_rr",    32'(reconfig_reset), 32'd0);
    watch_idle(20, saw);
    check("mid_rst_no_pend", 32'(saw), 32'd0);

    // Normal operation after the mid-run reset.
    exp_q.push_back(mk_exp(6, 0, 0, 1, 1, 0, 3, 14));
    pulse(0);
    wait_quiet(60);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    summary();
    $finish;
  end

  initial begin
    #2000000;
    note_fail("watchdog");
    summary();
    $finish;
  end

endmodule
